// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multicycle control unit: state enum,
// opcode map, ALU operations, mux encodings and the packed control word.
package ctrl_pkg;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_EXEC     = 4'd2,
    ST_WB_ALU   = 4'd3,
    ST_WB_IMM   = 4'd4,
    ST_MEM_RD   = 4'd5,
    ST_MEM_WB   = 4'd6,
    ST_MEM_WR   = 4'd7,
    ST_BR_CALC  = 4'd8,
    ST_BR_WR    = 4'd9,
    ST_JMP_CALC = 4'd10,
    ST_PC_WR    = 4'd11,
    ST_HALT     = 4'd12
  } state_t;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_LDI = 4'h8;
  localparam logic [3:0] OP_LD  = 4'h9;
  localparam logic [3:0] OP_ST  = 4'hA;
  localparam logic [3:0] OP_BZ  = 4'hB;
  localparam logic [3:0] OP_BC  = 4'hC;
  localparam logic [3:0] OP_JMP = 4'hD;
  localparam logic [3:0] OP_NOP = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;
  localparam logic [2:0] ALU_NOT = 3'd5;
  localparam logic [2:0] ALU_SHL = 3'd6;
  localparam logic [2:0] ALU_SHR = 3'd7;

  localparam logic [1:0] DATA_IMM  = 2'd0;
  localparam logic [1:0] DATA_MDR  = 2'd1;
  localparam logic [1:0] DATA_ALU  = 2'd2;
  localparam logic [1:0] DATA_ZERO = 2'd3;

  localparam logic [1:0] OPB_B    = 2'd0;
  localparam logic [1:0] OPB_ZERO = 2'd1;
  localparam logic [1:0] OPB_ONE  = 2'd2;
  localparam logic [1:0] OPB_OFF  = 2'd3;

  typedef struct packed {
    logic       pc_sel;
    logic       pc_wrt;
    logic       addr_sel;
    logic       ir_wrt;
    logic [1:0] data_sel;
    logic       rega_sel;
    logic       reg_wrt;
    logic       opa_sel;
    logic [1:0] opb_sel;
    logic [2:0] alu_sel;
    logic       re;
    logic       we;
    logic       halted;
  } ctrl_word_t;

  // Loads and stores address memory through IR[7:4], so they read that register as A.
  function automatic logic is_mem_op(input logic [3:0] opcode);
    return (opcode == OP_LD) || (opcode == OP_ST);
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// Control/status bundle between the control unit (master) and the datapath (slave).
interface control_unit_if;

  logic [3:0]  irout;
  logic [15:0] outA;
  logic        carry;

  logic        pc_sel;
  logic        pc_wrt;
  logic        addr_sel;
  logic        ir_wrt;
  logic [1:0]  data_sel;
  logic        rega_sel;
  logic        reg_wrt;
  logic        opa_sel;
  logic [1:0]  opb_sel;
  logic [2:0]  alu_sel;
  logic        re;
  logic        we;
  logic        carry_flag;
  logic        halted;

  modport master (
    input  irout, outA, carry,
    output pc_sel, pc_wrt, addr_sel, ir_wrt, data_sel, rega_sel, reg_wrt,
           opa_sel, opb_sel, alu_sel, re, we, carry_flag, halted
  );

  modport slave (
    output irout, outA, carry,
    input  pc_sel, pc_wrt, addr_sel, ir_wrt, data_sel, rega_sel, reg_wrt,
           opa_sel, opb_sel, alu_sel, re, we, carry_flag, halted
  );

endinterface

// File: rtl/ctrl_outdec.sv
// Combinational state-to-control-word decoder. Outputs depend on the state,
// with the opcode only refining A-register select in DECODE and the ALU op in EXEC.
module ctrl_outdec
  import ctrl_pkg::*;
(
  input  state_t     state,
  input  logic [3:0] opcode,
  output ctrl_word_t cw
);

  always_comb begin
    cw = '0;
    unique case (state)
      ST_FETCH: begin
        cw.addr_sel = 1'b0;
        cw.re       = 1'b1;
        cw.ir_wrt   = 1'b1;
        cw.opa_sel  = 1'b1;
        cw.opb_sel  = OPB_ONE;
        cw.alu_sel  = ALU_ADD;
      end
      ST_DECODE: begin
        cw.pc_sel   = 1'b1;
        cw.pc_wrt   = 1'b1;
        cw.rega_sel = is_mem_op(opcode);
      end
      ST_EXEC: begin
        cw.opb_sel = OPB_B;
        cw.alu_sel = opcode[2:0];
      end
      ST_WB_ALU: begin
        cw.data_sel = DATA_ALU;
        cw.reg_wrt  = 1'b1;
      end
      ST_WB_IMM: begin
        cw.data_sel = DATA_IMM;
        cw.reg_wrt  = 1'b1;
      end
      ST_MEM_RD: begin
        cw.rega_sel = 1'b1;
        cw.opb_sel  = OPB_ZERO;
        cw.alu_sel  = ALU_ADD;
        cw.addr_sel = 1'b1;
        cw.re       = 1'b1;
      end
      ST_MEM_WB: begin
        cw.data_sel = DATA_MDR;
        cw.reg_wrt  = 1'b1;
      end
      ST_MEM_WR: begin
        cw.rega_sel = 1'b1;
        cw.opb_sel  = OPB_ZERO;
        cw.alu_sel  = ALU_ADD;
        cw.addr_sel = 1'b1;
        cw.we       = 1'b1;
      end
      // Branch target is PC+1+sext(offset); PC already advanced in DECODE.
      ST_BR_CALC: begin
        cw.opa_sel = 1'b1;
        cw.opb_sel = OPB_OFF;
        cw.alu_sel = ALU_ADD;
      end
      ST_BR_WR, ST_PC_WR: begin
        cw.pc_sel = 1'b1;
        cw.pc_wrt = 1'b1;
      end
      ST_JMP_CALC: begin
        cw.opa_sel = 1'b0;
        cw.opb_sel = OPB_ZERO;
        cw.alu_sel = ALU_ADD;
      end
      ST_HALT: begin
        cw.halted = 1'b1;
      end
      default: cw = '0;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Multicycle control FSM for the 16-bit RISC core: state register, next-state
// logic and the sticky carry flag; control word decoding lives in ctrl_outdec.
module control_unit
  import ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  control_unit_if.master        bus
);

  state_t     state_q, state_d;
  logic       carry_flag_q, carry_flag_d;
  ctrl_word_t cw;
  ctrl_word_t cw_out;
  logic       branch_taken;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_FETCH;
      carry_flag_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      carry_flag_q <= carry_flag_d;
    end
  end

  assign branch_taken = ((bus.irout == OP_BZ) && (bus.outA == 16'h0000)) ||
                        ((bus.irout == OP_BC) && carry_flag_q);

  always_comb begin
    state_d      = state_q;
    carry_flag_d = carry_flag_q;
    unique case (state_q)
      ST_FETCH: state_d = ST_DECODE;
      ST_DECODE: begin
        if (!bus.irout[3]) begin
          state_d = ST_EXEC;
        end else begin
          unique case (bus.irout)
            OP_LDI:        state_d = ST_WB_IMM;
            OP_LD:         state_d = ST_MEM_RD;
            OP_ST:         state_d = ST_MEM_WR;
            OP_BZ, OP_BC:  state_d = ST_BR_CALC;
            OP_JMP:        state_d = ST_JMP_CALC;
            OP_NOP:        state_d = ST_FETCH;
            OP_HLT:        state_d = ST_HALT;
            default:       state_d = ST_FETCH;
          endcase
        end
      end
      // Only ADD and SUB produce a meaningful carry; all other ops keep the flag.
      ST_EXEC: begin
        if ((bus.irout == OP_ADD) || (bus.irout == OP_SUB)) begin
          carry_flag_d = bus.carry;
        end
        state_d = ST_WB_ALU;
      end
      ST_WB_ALU:   state_d = ST_FETCH;
      ST_WB_IMM:   state_d = ST_FETCH;
      ST_MEM_RD:   state_d = ST_MEM_WB;
      ST_MEM_WB:   state_d = ST_FETCH;
      ST_MEM_WR:   state_d = ST_FETCH;
      ST_BR_CALC:  state_d = branch_taken ? ST_BR_WR : ST_FETCH;
      ST_BR_WR:    state_d = ST_FETCH;
      ST_JMP_CALC: state_d = ST_PC_WR;
      ST_PC_WR:    state_d = ST_FETCH;
      ST_HALT:     state_d = ST_HALT;
      default:     state_d = ST_FETCH;
    endcase
  end

  ctrl_outdec u_outdec (
    .state  (state_q),
    .opcode (bus.irout),
    .cw     (cw)
  );

  // Reset masks every output combinationally so an aborted write never lingers.
  assign cw_out = rst ? '0 : cw;

  assign bus.pc_sel     = cw_out.pc_sel;
  assign bus.pc_wrt     = cw_out.pc_wrt;
  assign bus.addr_sel   = cw_out.addr_sel;
  assign bus.ir_wrt     = cw_out.ir_wrt;
  assign bus.data_sel   = cw_out.data_sel;
  assign bus.rega_sel   = cw_out.rega_sel;
  assign bus.reg_wrt    = cw_out.reg_wrt;
  assign bus.opa_sel    = cw_out.opa_sel;
  assign bus.opb_sel    = cw_out.opb_sel;
  assign bus.alu_sel    = cw_out.alu_sel;
  assign bus.re         = cw_out.re;
  assign bus.we         = cw_out.we;
  assign bus.halted     = cw_out.halted;
  assign bus.carry_flag = rst ? 1'b0 : carry_flag_q;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: walks each instruction class state by state
// and compares the full control word and carry flag against hand-derived values.
module tb_control_unit;

  logic clk;
  logic rst;

  control_unit_if bus ();

  control_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int assertCount = 0;
  int failCount   = 0;

  // Field order: pc_sel pc_wrt addr_sel ir_wrt data_sel rega_sel reg_wrt opa_sel opb_sel alu_sel re we halted
  localparam logic [16:0] W_ZERO     = 17'b0_0_0_0_00_0_0_0_00_000_0_0_0;
  localparam logic [16:0] W_FETCH    = 17'b0_0_0_1_00_0_0_1_10_000_1_0_0;
  localparam logic [16:0] W_DECODE   = 17'b1_1_0_0_00_0_0_0_00_000_0_0_0;
  localparam logic [16:0] W_DEC_MEM  = 17'b1_1_0_0_00_1_0_0_00_000_0_0_0;
  localparam logic [16:0] W_EXEC_ADD = 17'b0_0_0_0_00_0_0_0_00_000_0_0_0;
  localparam logic [16:0] W_EXEC_SUB = 17'b0_0_0_0_00_0_0_0_00_001_0_0_0;
  localparam logic [16:0] W_EXEC_AND = 17'b0_0_0_0_00_0_0_0_00_010_0_0_0;
  localparam logic [16:0] W_WB_ALU   = 17'b0_0_0_0_10_0_1_0_00_000_0_0_0;
  localparam logic [16:0] W_WB_IMM   = 17'b0_0_0_0_00_0_1_0_00_000_0_0_0;
  localparam logic [16:0] W_MEM_RD   = 17'b0_0_1_0_00_1_0_0_01_000_1_0_0;
  localparam logic [16:0] W_MEM_WB   = 17'b0_0_0_0_01_0_1_0_00_000_0_0_0;
  localparam logic [16:0] W_MEM_WR   = 17'b0_0_1_0_00_1_0_0_01_000_0_1_0;
  localparam logic [16:0] W_BR_CALC  = 17'b0_0_0_0_00_0_0_1_11_000_0_0_0;
  localparam logic [16:0] W_PC_WR    = 17'b1_1_0_0_00_0_0_0_00_000_0_0_0;
  localparam logic [16:0] W_JMP_CALC = 17'b0_0_0_0_00_0_0_0_01_000_0_0_0;
  localparam logic [16:0] W_HALT     = 17'b0_0_0_0_00_0_0_0_00_000_0_0_1;

  logic [16:0] observed;
  assign observed = {bus.pc_sel, bus.pc_wrt, bus.addr_sel, bus.ir_wrt, bus.data_sel,
                     bus.rega_sel, bus.reg_wrt, bus.opa_sel, bus.opb_sel, bus.alu_sel,
                     bus.re, bus.we, bus.halted};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] op, input logic [15:0] a, input logic c);
    bus.irout = op;
    bus.outA  = a;
    bus.carry = c;
  endtask

  task automatic checkOutput(input string tag, input logic [16:0] expected);
    assertCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
    end
  endtask

  task automatic checkCarry(input string tag, input logic expected);
    assertCount++;
    assert (bus.carry_flag === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: carry_flag observed %b expected %b", tag, bus.carry_flag, expected);
    end
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(4'hA, 16'h0000, 1'b0);
    tick();
    tick();
    checkOutput("reset_outputs", W_ZERO);
    checkCarry("reset_carry", 1'b0);
    rst = 1'b0;
    #1;
    checkOutput("first_fetch", W_FETCH);

    // ST, aborted by reset while the write strobe is up
    tick(); checkOutput("st_decode", W_DEC_MEM);
    tick(); checkOutput("st_mem_wr", W_MEM_WR);
    rst = 1'b1;
    #1;
    checkOutput("st_reset_abort", W_ZERO);
    tick(); checkOutput("st_reset_hold", W_ZERO);
    rst = 1'b0;
    #1;
    checkOutput("st_refetch", W_FETCH);

    // ADD with carry-out: flag set after EXEC
    applyStimulus(4'h0, 16'h1234, 1'b1);
    tick(); checkOutput("add_decode", W_DECODE);
    tick(); checkOutput("add_exec", W_EXEC_ADD);
    checkCarry("add_exec_carry_old", 1'b0);
    tick(); checkOutput("add_wb", W_WB_ALU);
    checkCarry("add_carry_set", 1'b1);
    tick(); checkOutput("add_fetch", W_FETCH);

    // LD: four cycles
    applyStimulus(4'h9, 16'h0000, 1'b0);
    tick(); checkOutput("ld_decode", W_DEC_MEM);
    tick(); checkOutput("ld_mem_rd", W_MEM_RD);
    tick(); checkOutput("ld_mem_wb", W_MEM_WB);
    tick(); checkOutput("ld_fetch", W_FETCH);
    checkCarry("ld_keeps_carry", 1'b1);

    // BZ taken
    applyStimulus(4'hB, 16'h0000, 1'b0);
    tick(); checkOutput("bz0_decode", W_DECODE);
    tick(); checkOutput("bz0_calc", W_BR_CALC);
    tick(); checkOutput("bz0_br_wr", W_PC_WR);
    tick(); checkOutput("bz0_fetch", W_FETCH);

    // BZ not taken
    applyStimulus(4'hB, 16'h0001, 1'b0);
    tick(); checkOutput("bz1_decode", W_DECODE);
    tick(); checkOutput("bz1_calc", W_BR_CALC);
    tick(); checkOutput("bz1_fetch", W_FETCH);

    // ADD without carry clears the flag
    applyStimulus(4'h0, 16'h0000, 1'b0);
    tick(); tick(); tick();
    checkCarry("add_carry_clear", 1'b0);
    tick(); checkOutput("add2_fetch", W_FETCH);

    // BC with flag clear: untaken, three cycles
    applyStimulus(4'hC, 16'h0000, 1'b1);
    tick(); checkOutput("bc0_decode", W_DECODE);
    tick(); checkOutput("bc0_calc", W_BR_CALC);
    tick(); checkOutput("bc0_fetch", W_FETCH);

    // SUB with borrow sets flag, AND leaves it, BC then taken
    applyStimulus(4'h1, 16'h0000, 1'b1);
    tick(); tick(); checkOutput("sub_exec", W_EXEC_SUB);
    tick(); checkCarry("sub_carry_set", 1'b1);
    tick();
    applyStimulus(4'h2, 16'h0000, 1'b0);
    tick(); tick(); checkOutput("and_exec", W_EXEC_AND);
    tick(); checkCarry("and_keeps_carry", 1'b1);
    tick();
    applyStimulus(4'hC, 16'h0000, 1'b0);
    tick(); checkOutput("bc1_decode", W_DECODE);
    tick(); checkOutput("bc1_calc", W_BR_CALC);
    tick(); checkOutput("bc1_br_wr", W_PC_WR);
    tick(); checkOutput("bc1_fetch", W_FETCH);

    // JMP
    applyStimulus(4'hD, 16'h0040, 1'b0);
    tick(); checkOutput("jmp_decode", W_DECODE);
    tick(); checkOutput("jmp_calc", W_JMP_CALC);
    tick(); checkOutput("jmp_pc_wr", W_PC_WR);
    tick(); checkOutput("jmp_fetch", W_FETCH);

    // LDI
    applyStimulus(4'h8, 16'h0000, 1'b0);
    tick(); checkOutput("ldi_decode", W_DECODE);
    tick(); checkOutput("ldi_wb", W_WB_IMM);
    tick(); checkOutput("ldi_fetch", W_FETCH);

    // NOP
    applyStimulus(4'hE, 16'h0000, 1'b0);
    tick(); checkOutput("nop_decode", W_DECODE);
    tick(); checkOutput("nop_fetch", W_FETCH);

    // HLT stalls until reset
    applyStimulus(4'hF, 16'h0000, 1'b0);
    tick(); checkOutput("hlt_decode", W_DECODE);
    for (int i = 0; i < 10; i++) begin
      tick();
      checkOutput($sformatf("hlt_stall_%0d", i), W_HALT);
    end
    checkCarry("hlt_keeps_carry", 1'b1);
    rst = 1'b1;
    #1;
    checkOutput("hlt_reset", W_ZERO);
    tick();
    rst = 1'b0;
    applyStimulus(4'hE, 16'h0000, 1'b0);
    #1;
    checkOutput("hlt_refetch", W_FETCH);
    checkCarry("hlt_reset_carry", 1'b0);
    tick(); checkOutput("post_hlt_decode", W_DECODE);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
